// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fetch
//  Purpose  : Direct-mapped, read-only I-cache for the fetch stage; 4-word
//             line refill over a valid-handshake memory port.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] InstrF,
    output logic                  StallF,
    output logic                  MemReq,
    output logic [DATA_WIDTH-1:0] MemAddr,
    input  logic [DATA_WIDTH-1:0] MemRData,
    input  logic                  MemValid,
    output logic [31:0]           MissCount
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int LINE_W = DATA_WIDTH - 4;
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            beat_q, beat_d;
    logic [LINE_W-1:0]     base_q, base_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][LINE_WORDS];

    logic [1:0]            w_offset;
    logic [IDX_W-1:0]      w_index;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_fill_index;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_beat_done;
    logic                  w_line_done;
    logic                  w_miss_start;
    logic                  w_unused_pcf;

    assign w_offset     = PCF[3:2];
    assign w_index      = PCF[4 +: IDX_W];
    assign w_tag        = PCF[DATA_WIDTH-1 -: TAG_W];
    assign w_hit        = valid_q[w_index] && (tag_q[w_index] == w_tag);
    assign w_fill_index = base_q[IDX_W-1:0];
    assign w_fill_tag   = base_q[LINE_W-1 -: TAG_W];
    assign w_beat_done  = (state_q == REFILL) && MemValid;
    assign w_line_done  = w_beat_done && (beat_q == 2'd3);
    assign w_miss_start = (state_q == IDLE) && !w_hit;
    assign w_unused_pcf = ^PCF[1:0];

    assign MemAddr   = {base_q, beat_q, 2'b00};
    assign MissCount = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        miss_cnt_d = miss_cnt_q;
        StallF     = 1'b1;
        InstrF     = NOP;
        MemReq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_hit) begin
                    StallF = 1'b0;
                    InstrF = data_q[w_index][w_offset];
                end else begin
                    state_d    = REFILL;
                    base_d     = PCF[DATA_WIDTH-1:4];
                    beat_d     = 2'd0;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
            end
            REFILL: begin
                MemReq = 1'b1;
                if (MemValid) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset presents the view of an empty cache and silences the memory port.
        if (rst) begin
            StallF = 1'b1;
            InstrF = NOP;
            MemReq = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= 2'd0;
            base_q     <= '0;
            miss_cnt_q <= 32'd0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            miss_cnt_q <= miss_cnt_d;
            if (w_miss_start) begin
                valid_q[w_index] <= 1'b0;
            end else if (w_line_done) begin
                valid_q[w_fill_index] <= 1'b1;
            end
        end
    end

    // Line storage needs no reset; the valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst && w_beat_done) begin
            data_q[w_fill_index][beat_q] <= MemRData;
            if (beat_q == 2'd3) begin
                tag_q[w_fill_index] <= w_fill_tag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_icache_fetch
//  Purpose  : Scoreboard bench for icache_fetch; memory returns data = address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_icache_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        StallF;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemRData;
    logic        MemValid;
    logic [31:0] MissCount;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_mode = 0;
    int          wcnt     = 0;
    bit          fetch_active = 1'b0;
    bit          prev_wait    = 1'b0;
    logic [31:0] prev_addr    = '0;
    logic [31:0] exp_instr [$];
    logic [31:0] exp_addr  [$];

    icache_fetch #(
        .DATA_WIDTH (32),
        .SETS       (64),
        .LINE_WORDS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCF       (PCF),
        .InstrF    (InstrF),
        .StallF    (StallF),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .MemRData  (MemRData),
        .MemValid  (MemValid),
        .MissCount (MissCount)
    );

    assign MemRData = MemAddr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: mode 0 accepts every beat, mode 1 accepts every 3rd cycle.
    initial begin
        MemValid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_mode == 0) begin
                MemValid = 1'b1;
            end else if (MemReq) begin
                wcnt++;
                MemValid = (wcnt % 3 == 0);
            end else begin
                wcnt     = 0;
                MemValid = 1'b0;
            end
        end
    end

    // Monitor: pops expected instructions and refill beats as the DUT presents them.
    always @(negedge clk) begin
        if (!rst && fetch_active && !StallF) begin
            if (exp_instr.size() == 0) chk("instr_unexpected", InstrF, 32'hDEAD_BEEF);
            else chk("InstrF", InstrF, exp_instr.pop_front());
        end
        if (!rst && MemReq && MemValid) begin
            if (exp_addr.size() == 0) chk("beat_unexpected", MemAddr, 32'hDEAD_BEEF);
            else chk("MemAddr", MemAddr, exp_addr.pop_front());
        end
        if (!rst && MemReq && prev_wait) chk("MemAddr_hold", MemAddr, prev_addr);
        prev_wait = !rst && MemReq && !MemValid;
        prev_addr = MemAddr;
    end

    // Entered and left at posedge+1; counts stalled cycles until the hit is delivered.
    task automatic fetch(input logic [31:0] addr, input bit miss, input int exp_stall,
                         input logic [31:0] exp_mc);
        int stalls;
        stalls = 0;
        exp_instr.push_back(addr);
        if (miss) begin
            for (int b = 0; b < 4; b++) exp_addr.push_back({addr[31:4], 4'b0} + 32'(b * 4));
        end
        PCF          = addr;
        fetch_active = 1'b1;
        forever begin
            @(negedge clk);
            if (!StallF) break;
            stalls++;
            if (stalls > 200) begin
                chk("stall_timeout", 32'(stalls), 32'(exp_stall));
                break;
            end
        end
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
        chk("MissCount", MissCount, exp_mc);
        if (!miss) chk("MemReq_on_hit", {31'd0, MemReq}, 32'd0);
        @(posedge clk);
        #1;
        fetch_active = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        PCF = 32'hBFC0_0000;
        @(negedge clk);
        chk("rst_StallF", {31'd0, StallF}, 32'd1);
        chk("rst_InstrF", InstrF, 32'h0000_0013);
        chk("rst_MemReq", {31'd0, MemReq}, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_MissCount", MissCount, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold fetch and sequential hits in the same line
        fetch(32'hBFC0_0000, 1'b1, 5, 32'd1);
        fetch(32'hBFC0_0004, 1'b0, 0, 32'd1);
        fetch(32'hBFC0_0008, 1'b0, 0, 32'd1);
        fetch(32'hBFC0_000C, 1'b0, 0, 32'd1);

        // Conflict on index 0
        fetch(32'hBFC0_0400, 1'b1, 5, 32'd2);
        fetch(32'hBFC0_0000, 1'b1, 5, 32'd3);

        // Two wait cycles per beat
        mem_mode = 1;
        fetch(32'h0000_1000, 1'b1, 13, 32'd4);
        mem_mode = 0;
        fetch(32'h0000_1004, 1'b0, 0, 32'd4);
        fetch(32'h0000_1008, 1'b0, 0, 32'd4);
        fetch(32'h0000_100C, 1'b0, 0, 32'd4);

        // Reset after two beats of a refill
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        PCF = 32'hBFC0_0000;
        for (int b = 0; b < 4; b++) exp_addr.push_back(32'hBFC0_0000 + 32'(b * 4));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_MemReq", {31'd0, MemReq}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_MemReq_after", {31'd0, MemReq}, 32'd0);
        chk("midrst_MissCount", MissCount, 32'd0);
        chk("midrst_beats_seen", 32'(exp_addr.size()), 32'd2);
        exp_addr.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetch(32'hBFC0_0000, 1'b1, 5, 32'd1);

        // PCF moves mid-refill; the latched line completes first
        for (int b = 0; b < 4; b++) exp_addr.push_back(32'h0000_0010 + 32'(b * 4));
        PCF = 32'h0000_0010;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        fetch(32'h0000_0020, 1'b1, 8, 32'd3);
        fetch(32'h0000_0010, 1'b0, 0, 32'd3);

        repeat (3) @(posedge clk);
        chk("instr_queue_empty", 32'(exp_instr.size()), 32'd0);
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache for the fetch stage of the pipelined RISC-V core. It takes the fetch address `PCF` from the PC register and returns `InstrF` to the fetch/decode pipeline register. On a miss it stalls the front end through `StallF`, which drives the PC `en` input and the F/D register enable, and refills a 4-word line from instruction memory over a valid-handshake port.

## Interface
- `DATA_WIDTH`, 32, instruction and address width.
- `SETS`, 64, number of lines; a power of two ≥ 2.
- `LINE_WORDS`, 4, words per line; fixed at 4.
- `clk` in 1, the single clock; all state updates on the rising edge.
- `rst` in 1, synchronous, active-high reset.
- `PCF` in 32, fetch address; bits [1:0] are ignored.
- `InstrF` out 32, the instruction at `PCF`; valid when `StallF`=0.
- `StallF` out 1, 1 = front end must hold `PCF` and the F/D register.
- `MemReq` out 1, refill request; 1 = `MemAddr` is valid.
- `MemAddr` out 32, word address of the current refill beat.
- `MemRData` in 32, refill data.
- `MemValid` in 1, memory accepts the current beat and returns `MemRData` for it in the same cycle.
- `MissCount` out 32, count of misses since reset (performance counter).

## Operation
- Address split:
  - offset = `PCF[3:2]`.
  - index = `PCF[3+log2(SETS):4]`.
  - tag = the remaining upper bits (22 bits when `SETS`=64).
- Storage per set: a valid bit, a tag, and 4 data words.
- The FSM has two states: IDLE and REFILL.
- IDLE behaviour:
  - hit = valid[index] && tag match. The lookup is combinational.
  - On a hit: `InstrF` = data[index][offset], `StallF`=0, `MemReq`=0.
  - On a miss: `StallF`=1 and `InstrF`=32'h00000013 (NOP).
  - On a miss, at the clock edge: latch the line base address {`PCF[31:4]`, 4'b0}, clear valid[index], set beat=0, increment `MissCount`, and move to REFILL.
- REFILL behaviour:
  - `StallF`=1, `InstrF`=32'h00000013, `MemReq`=1.
  - `MemAddr` = latched base + 4·beat.
  - On a cycle with `MemValid`=1: write `MemRData` into data[latched index][beat] and increment beat.
  - On the beat 3 transfer: set valid and write the tag, then return to IDLE.
  - `MemAddr` holds stable until `MemValid` is seen. `MemValid` while `MemReq`=0 is ignored.
- `PCF` changes during REFILL are ignored; the latched address governs the refill. When the FSM returns to IDLE, the current `PCF` is looked up normally and may miss again.
- `MissCount` wraps modulo 2^32.
- No writes and no self-modifying-code support; coherence with data memory is out of scope.

## Timing
- Reset (`rst`=1 at an edge) clears:
  - all valid bits;
  - state to IDLE, beat to 0, `MissCount` to 0.
- While `rst`=1:
  - `MemReq`=0.
  - `StallF`/`InstrF` follow the IDLE lookup of an empty cache: `StallF`=1, `InstrF`=32'h00000013.
- Reset mid-refill:
  - The refill is aborted and the partial line stays invalid.
  - No further `MemReq` until a new miss occurs after reset is released.
- Hit latency: 0 cycles, combinational from `PCF` to `InstrF`.
- Miss penalty with `MemValid` held at 1: `StallF`=1 for 5 cycles (the miss-detect cycle plus 4 beats). The hit is delivered in the 6th cycle.
- With N wait cycles per beat: `StallF` is high for 1 + 4·(N+1) cycles.
- `MissCount` increments on the edge that leaves IDLE on a miss, exactly once per miss.

## Test plan
1. **Cold fetch.** Release `rst`, `PCF`=0xBFC00000; memory returns data = address with `MemValid`=1 every cycle.
   - `StallF` is high for 5 cycles.
   - `MemAddr` steps 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C.
   - Then `InstrF`=0xBFC00000, `StallF`=0, `MissCount`=1.
2. **Sequential hits after test 1.** `PCF`=0xBFC00004, then 0xBFC00008, then 0xBFC0000C.
   - `StallF`=0 on each.
   - `InstrF` = 0xBFC00004, 0xBFC00008, 0xBFC0000C respectively.
   - `MemReq`=0; `MissCount` stays 1.
3. **Conflict.** `PCF`=0xBFC00400 (same index, different tag) → miss and refill. Then `PCF`=0xBFC00000 → miss and refill again.
   - `MissCount`=3.
   - Final `InstrF`=0xBFC00000.
4. **Wait states.** `MemValid` pulses every 3rd cycle during the refill of 0x00001000.
   - `MemAddr` holds each beat until accepted.
   - `StallF` is high for 13 cycles.
   - Line contents are correct.
5. **Reset mid-refill.** Assert `rst` after 2 beats of the refill of 0xBFC00000.
   - `MemReq`=0 next cycle; `MissCount`=0.
   - A re-fetch of 0xBFC00000 issues all 4 beats starting at 0xBFC00000.
6. **`PCF` change during refill.** Switch `PCF` from 0x00000010 to 0x00000020 during the refill.
   - `MemAddr` stays within 0x00000010–0x0000001C.
   - After the return to IDLE, 0x00000020 misses: `MissCount` increments and `MemAddr` starts at 0x00000020.
